// File: rtl/reflet_fpu_mult_sched_pkg.sv
// Shared definitions for the reflet FPU schedulers: FSM encoding and operand-mode codes.
package reflet_fpu_mult_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    MULT = 3'd2,
    BACK = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic MODE_FLOAT = 1'b0;
  localparam logic MODE_INT   = 1'b1;

  // Int-mode products still need the float-to-int stage before responding.
  function automatic state_t after_mult(input logic mode);
    return (mode == MODE_INT) ? BACK : RESP;
  endfunction

endpackage

// File: rtl/reflet_fpu_mult_sched_if.sv
// Request/response bundle between FPU clients (master) and the multiplier scheduler (slave).
interface reflet_fpu_mult_sched_if #(
  parameter int NREQ     = 2,
  parameter int int_size = 32
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          req_mode;
  logic [NREQ*int_size-1:0] req_a;
  logic [NREQ*int_size-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [int_size-1:0]      rsp_data;

  modport master (
    output req_valid, req_mode, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/reflet_fpu_units.sv
// Combinational reflet FPU units: int-to-float, float multiply, float-to-int.
// Truncating rounding, denormals flushed to zero, overflow to infinity / saturation.
module reflet_int_to_float #(
  parameter int int_size = 32
) (
  input  logic [int_size-1:0] value,
  output logic [31:0]         result
);
  logic [int_size-1:0] mag_s;
  logic [6:0]          msb_s;
  logic [63:0]         norm_s;

  // Normalise the magnitude so its leading one sits at bit 63.
  always_comb begin
    mag_s = value[int_size-1] ? -value : value;
    msb_s = 7'd0;
    for (int i = 0; i < int_size; i++) begin
      if (mag_s[i]) msb_s = 7'(i);
      else          msb_s = msb_s;
    end
    norm_s = 64'(mag_s) << (7'd63 - msb_s);
    if (mag_s == '0) result = 32'd0;
    else             result = {value[int_size-1], 8'd127 + {1'b0, msb_s}, norm_s[62:40]};
  end
endmodule

module reflet_float_mult (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        enable,
  output logic [31:0] result
);
  logic              sign_s;
  logic [47:0]       prod_s;
  logic signed [9:0] exp_s;
  logic [22:0]       mant_s;

  // Mantissa product with one-bit renormalisation, then range classification.
  always_comb begin
    sign_s = a[31] ^ b[31];
    prod_s = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    exp_s  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod_s[47]) begin
      mant_s = prod_s[46:24];
      exp_s  = exp_s + 10'sd1;
    end else begin
      mant_s = prod_s[45:23];
      exp_s  = exp_s;
    end
    if (!enable)                                          result = 32'd0;
    else if (a[30:23] == 8'd0 || b[30:23] == 8'd0)        result = {sign_s, 31'd0};
    else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)      result = {sign_s, 8'hFF, 23'd0};
    else if (exp_s >= 10'sd255)                           result = {sign_s, 8'hFF, 23'd0};
    else if (exp_s <= 10'sd0)                             result = {sign_s, 31'd0};
    else                                                  result = {sign_s, exp_s[7:0], mant_s};
  end
endmodule

module reflet_float_to_int #(
  parameter int int_size = 32
) (
  input  logic [31:0]         value,
  output logic [int_size-1:0] result
);
  logic [7:0]          exp_s;
  logic [95:0]         wide_s;
  logic [int_size-1:0] mag_s;

  // Truncate toward zero; magnitudes beyond the signed range saturate.
  always_comb begin
    exp_s  = value[30:23];
    wide_s = {72'd0, 1'b1, value[22:0]} << (exp_s - 8'd127);
    mag_s  = int_size'(wide_s >> 23);
    if (exp_s < 8'd127)                               result = '0;
    else if ({24'd0, exp_s} >= 32'(int_size + 126))   result = value[31] ? {1'b1, {(int_size-1){1'b0}}}
                                                                         : {1'b0, {(int_size-1){1'b1}}};
    else                                              result = value[31] ? -mag_s : mag_s;
  end
endmodule

// File: rtl/reflet_rr_arbiter.sv
// Round-robin pick: first requesting index after last_grant, modulo NREQ.
module reflet_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_grant,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any
);
  logic [ID_W-1:0] idx_s;

  // Scan farthest-first so the nearest requester after last_grant overwrites.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    idx_s     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx_s = ID_W'((int'(last_grant) + k) % NREQ);
      if (req[idx_s]) begin
        grant_idx = idx_s;
        any       = 1'b1;
      end else begin
        grant_idx = grant_idx;
        any       = any;
      end
    end
    grant = any ? (NREQ'(1'b1) << grant_idx) : '0;
  end
endmodule

// File: rtl/reflet_fpu_mult_sched.sv
// Round-robin scheduler sharing one float multiplier among NREQ clients,
// with optional int<->float conversion around it. One operation in flight.
module reflet_fpu_mult_sched
  import reflet_fpu_mult_sched_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int int_size = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  reflet_fpu_mult_sched_if.slave bus,
  output logic                  busy
);
  localparam int ID_W = $clog2(NREQ);

  state_t              state_r, state_s;
  logic [ID_W-1:0]     last_grant_r, grant_r;
  logic                mode_r;
  logic [int_size-1:0] a_r, b_r, result_r;
  logic [31:0]         fa_r, fb_r, prod_r;

  logic [NREQ-1:0]     grant_s;
  logic [ID_W-1:0]     grant_idx_s;
  logic                any_s;
  logic [int_size-1:0] sel_a_s, sel_b_s, f2i_s;
  logic                sel_mode_s;
  logic [31:0]         i2f_a_s, i2f_b_s, mult_s;

  reflet_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req(bus.req_valid), .last_grant(last_grant_r),
    .grant(grant_s), .grant_idx(grant_idx_s), .any(any_s)
  );

  reflet_int_to_float #(.int_size(int_size)) u_i2f_a (.value(a_r), .result(i2f_a_s));
  reflet_int_to_float #(.int_size(int_size)) u_i2f_b (.value(b_r), .result(i2f_b_s));
  reflet_float_mult u_mult (.a(fa_r), .b(fb_r), .enable(1'b1), .result(mult_s));
  reflet_float_to_int #(.int_size(int_size)) u_f2i (.value(prod_r), .result(f2i_s));

  assign sel_a_s    = bus.req_a[grant_idx_s*int_size +: int_size];
  assign sel_b_s    = bus.req_b[grant_idx_s*int_size +: int_size];
  assign sel_mode_s = bus.req_mode[grant_idx_s];

  // Accept strobe is combinational and only offered while idle and out of reset.
  assign bus.req_ready = (state_r == IDLE && !reset) ? grant_s : '0;
  assign bus.rsp_valid = (state_r == RESP);
  assign bus.rsp_id    = grant_r;
  assign bus.rsp_data  = result_r;
  assign busy          = (state_r != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) state_s = (sel_mode_s == MODE_INT) ? CONV : MULT;
        else       state_s = IDLE;
      end
      CONV: state_s = MULT;
      MULT: state_s = after_mult(mode_r);
      BACK: state_s = RESP;
      RESP: begin
        if (bus.rsp_ready) state_s = IDLE;
        else               state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: each stage captures its unit output; float operands load directly on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= ID_W'(NREQ - 1);
      grant_r      <= '0;
      mode_r       <= 1'b0;
      a_r          <= '0;
      b_r          <= '0;
      fa_r         <= 32'd0;
      fb_r         <= 32'd0;
      prod_r       <= 32'd0;
      result_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_s) begin
            grant_r <= grant_idx_s;
            mode_r  <= sel_mode_s;
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            fa_r    <= sel_a_s[31:0];
            fb_r    <= sel_b_s[31:0];
          end
        end
        CONV: begin
          fa_r <= i2f_a_s;
          fb_r <= i2f_b_s;
        end
        MULT: begin
          prod_r <= mult_s;
          if (mode_r == MODE_FLOAT) result_r <= int_size'(mult_s);
        end
        BACK: result_r <= f2i_s;
        RESP: begin
          if (bus.rsp_ready) last_grant_r <= grant_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_fpu_mult_sched.sv
// Scoreboard bench: stimulus pushes expected {id,data,latency} in grant order,
// a negedge monitor checks grants, latency, hold under backpressure and responses.
module tb_reflet_fpu_mult_sched;
  localparam int NREQ = 2;
  localparam int W    = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;

  reflet_fpu_mult_sched_if #(.NREQ(NREQ), .int_size(W)) bus ();

  reflet_fpu_mult_sched #(.NREQ(NREQ), .int_size(W)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:0]  id;
    logic [31:0] data;
    logic [7:0]  lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   tmo_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: sole owner of the counters and of popping the scoreboard.
  int          acc_cyc = 0;
  int          tmo_seen = 0;
  logic        rsp_seen = 1'b0;
  logic        prev_hs = 1'b0;
  logic [31:0] prev_data = 32'd0;
  logic [0:0]  prev_id = 1'b0;
  logic [31:0] gidx;

  always begin
    @(negedge clk or posedge reset);
    if (reset) begin
      #1;
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_busy",      32'(busy),          32'd0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
      chk("reset_rsp_data",  bus.rsp_data,       32'd0);
      chk("reset_rsp_id",    32'(bus.rsp_id),    32'd0);
      exp_q.delete();
      prev_hs  = 1'b0;
      rsp_seen = 1'b0;
    end else begin
      if (tmo_cnt != tmo_seen) begin
        chk("bounded_wait", 32'(tmo_cnt), 32'(tmo_seen));
        tmo_seen = tmo_cnt;
      end
      if (prev_hs) begin
        chk("bubble_busy",      32'(busy),          32'd0);
        chk("bubble_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end
      if (busy) chk("ready_while_busy", 32'(bus.req_ready), 32'd0);
      if (bus.req_ready != '0) begin
        chk("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
        gidx = bus.req_ready[1] ? 32'd1 : 32'd0;
        if (exp_q.size() == 0) chk("grant_expected", 32'd0, 32'd1);
        else                   chk("grant_id", gidx, 32'(exp_q[0].id));
        acc_cyc  = cyc;
        rsp_seen = 1'b0;
      end
      if (bus.rsp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          if (exp_q.size() != 0) chk("latency", 32'(cyc - acc_cyc), 32'(exp_q[0].lat));
        end else begin
          chk("hold_data",  bus.rsp_data,       prev_data);
          chk("hold_id",    32'(bus.rsp_id),    32'(prev_id));
          chk("hold_busy",  32'(busy),          32'd1);
        end
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("rsp_expected", 32'd0, 32'd1);
          end else begin
            chk("rsp_id",   32'(bus.rsp_id), 32'(exp_q[0].id));
            chk("rsp_data", bus.rsp_data,    exp_q[0].data);
            void'(exp_q.pop_front());
          end
        end
      end
      prev_hs   = bus.rsp_valid && bus.rsp_ready;
      prev_data = bus.rsp_data;
      prev_id   = bus.rsp_id;
    end
  end

  task automatic present(input int id, input logic mode, input logic [31:0] a, input logic [31:0] b);
    bus.req_mode[id]        = mode;
    bus.req_a[id*W +: W]    = a;
    bus.req_b[id*W +: W]    = b;
    bus.req_valid[id]       = 1'b1;
  endtask

  task automatic expect_rsp(input int id, input logic [31:0] data, input int lat);
    exp_q.push_back('{id: 1'(id), data: data, lat: 8'(lat)});
  endtask

  // Advance one clock; a requester seen accepted drops its valid after the edge.
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = reset ? '0 : (bus.req_ready & bus.req_valid);
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) tmo_cnt++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rem0, rem1, n;
    bus.req_valid = '0;
    bus.req_mode  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #2;
    do_reset(3);

    // Float mode: 5.0 * 15.0 = 75.0
    expect_rsp(0, 32'h42960000, 2);
    present(0, 1'b0, 32'h40A00000, 32'h41700000);
    wait_idle(20);

    // Int mode on requester 1
    expect_rsp(1, 32'hFFFFFE5C, 4);
    present(1, 1'b1, 32'd28, 32'hFFFFFFF1);
    wait_idle(20);
    expect_rsp(1, 32'd144, 4);
    present(1, 1'b1, 32'hFFFFFFF4, 32'hFFFFFFF4);
    wait_idle(20);
    expect_rsp(1, 32'd0, 4);
    present(1, 1'b1, 32'd0, 32'd100);
    wait_idle(20);

    // Fairness right after reset: 0,1,0,1 with both kept requesting
    do_reset(2);
    expect_rsp(0, 32'h40C00000, 2);
    expect_rsp(1, 32'h40100000, 2);
    expect_rsp(0, 32'h40C00000, 2);
    expect_rsp(1, 32'h40100000, 2);
    present(0, 1'b0, 32'h40000000, 32'h40400000);
    present(1, 1'b0, 32'h3FC00000, 32'h3FC00000);
    rem0 = 1;
    rem1 = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
      if (!bus.req_valid[0] && rem0 > 0) begin present(0, 1'b0, 32'h40000000, 32'h40400000); rem0--; end
      if (!bus.req_valid[1] && rem1 > 0) begin present(1, 1'b0, 32'h3FC00000, 32'h3FC00000); rem1--; end
    end
    if (n >= 60) tmo_cnt++;
    wait_idle(20);

    // Backpressure: int 7*6 held 5 cycles in RESP while requester 1 waits
    bus.rsp_ready = 1'b0;
    expect_rsp(0, 32'd42, 4);
    expect_rsp(1, 32'h41200000, 2);
    present(0, 1'b1, 32'd7, 32'd6);
    present(1, 1'b0, 32'h40A00000, 32'h40000000);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) tmo_cnt++;
    repeat (5) step();
    bus.rsp_ready = 1'b1;
    wait_idle(30);

    // Withdrawal: requester 1 drops before being granted, only requester 0 served
    expect_rsp(0, 32'hC0C00000, 2);
    present(0, 1'b0, 32'hC0000000, 32'h40400000);
    present(1, 1'b0, 32'h40000000, 32'h40000000);
    step();
    bus.req_valid[1] = 1'b0;
    wait_idle(20);
    repeat (4) step();

    // Reset while an int-mode operation of requester 1 is in MULT
    expect_rsp(1, 32'd81, 4);
    present(1, 1'b1, 32'd9, 32'd9);
    n = 0;
    while (bus.req_valid[1] && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) tmo_cnt++;
    @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    expect_rsp(0, 32'd15, 4);
    expect_rsp(1, 32'h40100000, 2);
    present(0, 1'b1, 32'd3, 32'd5);
    present(1, 1'b0, 32'h3FC00000, 32'h3FC00000);
    wait_idle(40);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
